// File: rtl/bsg_nonsynth_clock_period_monitor.sv
// Measures each period of a free-running monitored clock in sampling-clock cycles and reports it
// over valid/ready. Define BSG_CLOCK_MON_MINMAX_EN to add min_o/max_o period tracking.
module bsg_nonsynth_clock_period_monitor #(
    parameter int width_p           = 16,
    parameter int expected_cycles_p = 10,
    parameter int tolerance_p       = 1,
    parameter int timeout_p         = 1024
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               mon_clk_i,
    input  logic               clear_i,
    output logic               v_o,
    output logic [width_p-1:0] period_o,
    input  logic               ready_i,
    output logic               err_o,
    output logic               overrun_o,
    output logic               stall_o
`ifdef BSG_CLOCK_MON_MINMAX_EN
    ,
    output logic [width_p-1:0] min_o,
    output logic [width_p-1:0] max_o
`endif
);

    // Bounds kept one bit wider than the counter so expected+tolerance cannot wrap.
    localparam logic [width_p:0]   LO_C      = (expected_cycles_p > tolerance_p)
                                             ? (width_p+1)'(expected_cycles_p - tolerance_p) : '0;
    localparam logic [width_p:0]   HI_C      = (width_p+1)'(expected_cycles_p + tolerance_p);
    localparam logic [width_p-1:0] TIMEOUT_C = width_p'(timeout_p);
    localparam logic [width_p-1:0] SAT_C     = '1;

    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_STALL} state_e;

    logic               r_s1, r_s2, r_s3;
    logic [width_p-1:0] r_cnt;
    state_e             r_state;
    logic               r_stall;
    logic               r_v;
    logic [width_p-1:0] r_period;
    logic               r_err;
    logic               r_overrun;

    logic               w_rise;
    logic               w_meas_v;
    logic               w_stall_hit;
    logic [width_p:0]   w_meas_ext;
    logic               w_out_tol;
    logic               w_err_set;
    logic               w_ovr_set;

    assign w_rise      = r_s2 & ~r_s3;
    assign w_meas_v    = (r_state == S_ARMED) & w_rise;
    assign w_stall_hit = (r_state == S_ARMED) & ~w_rise & (r_cnt == TIMEOUT_C);
    assign w_meas_ext  = {1'b0, r_cnt};
    assign w_out_tol   = (w_meas_ext < LO_C) | (w_meas_ext > HI_C);
    assign w_err_set   = (w_meas_v & w_out_tol) | w_stall_hit;
    assign w_ovr_set   = w_meas_v & r_v & ~ready_i;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= mon_clk_i;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i)            r_cnt <= '0;
        else if (w_rise)        r_cnt <= width_p'(1);
        else if (r_cnt != SAT_C) r_cnt <= r_cnt + width_p'(1);
    end

    // A rise out of STALL only re-arms; the stalled interval is never reported.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state <= S_IDLE;
            r_stall <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE:  if (w_rise) r_state <= S_ARMED;
                S_ARMED: if (w_stall_hit) begin
                    r_state <= S_STALL;
                    r_stall <= 1'b1;
                end
                S_STALL: if (w_rise) begin
                    r_state <= S_ARMED;
                    r_stall <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_stall <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_v      <= 1'b0;
            r_period <= '0;
        end else if (w_meas_v && (!r_v || ready_i)) begin
            r_v      <= 1'b1;
            r_period <= r_cnt;
        end else if (r_v && ready_i) begin
            r_v      <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_err     <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (w_err_set)    r_err <= 1'b1;
            else if (clear_i) r_err <= 1'b0;
            if (w_ovr_set)    r_overrun <= 1'b1;
            else if (clear_i) r_overrun <= 1'b0;
        end
    end

`ifdef BSG_CLOCK_MON_MINMAX_EN
    logic [width_p-1:0] r_min, r_max;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_min <= '1;
            r_max <= '0;
        end else if (w_meas_v) begin
            r_min <= (clear_i || r_cnt < r_min) ? r_cnt : r_min;
            r_max <= (clear_i || r_cnt > r_max) ? r_cnt : r_max;
        end else if (clear_i) begin
            r_min <= '1;
            r_max <= '0;
        end
    end

    assign min_o = r_min;
    assign max_o = r_max;
`endif

    assign v_o       = r_v;
    assign period_o  = r_period;
    assign err_o     = r_err;
    assign overrun_o = r_overrun;
    assign stall_o   = r_stall;

endmodule

// File: tb/tb_bsg_nonsynth_clock_period_monitor.sv
// Directed bench: the monitored clock is driven in lock-step with clk_i; expected periods are
// queued at each driven rising edge and popped when the monitor hands a report over.
module tb_bsg_nonsynth_clock_period_monitor;
    localparam int W       = 16;
    localparam int TIMEOUT = 1024;

    logic         clk = 1'b0;
    logic         reset_i, mon_clk_i, clear_i, ready_i;
    logic         v_o, err_o, overrun_o, stall_o;
    logic [W-1:0] period_o;
`ifdef BSG_CLOCK_MON_MINMAX_EN
    logic [W-1:0] min_o, max_o;
`endif

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int last_rise = 0;
    bit armed    = 1'b0;
    bit sb_en    = 1'b1;
    bit clr_pend = 1'b0;
    int sbq[$];

    bsg_nonsynth_clock_period_monitor #(
        .width_p(W), .expected_cycles_p(10), .tolerance_p(1), .timeout_p(TIMEOUT)
    ) dut (
        .clk_i(clk), .reset_i(reset_i), .mon_clk_i(mon_clk_i), .clear_i(clear_i),
        .v_o(v_o), .period_o(period_o), .ready_i(ready_i),
        .err_o(err_o), .overrun_o(overrun_o), .stall_o(stall_o)
`ifdef BSG_CLOCK_MON_MINMAX_EN
        , .min_o(min_o), .max_o(max_o)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clk_i cycle; entered and left 1ns after a rising edge.
    task automatic step();
        int e;
        clear_i  = clr_pend;
        clr_pend = 1'b0;
        @(negedge clk);
        if (v_o === 1'b1 && ready_i) begin
            if (sbq.size() == 0) chk("unexpected_report", 32'(period_o), 32'hFFFF_FFFF);
            else begin
                e = sbq.pop_front();
                chk("period", 32'(period_o), 32'(e));
            end
        end
        @(posedge clk);
        #1;
        clear_i = 1'b0;
        cyc++;
    endtask

    task automatic set_mon(input logic b);
        if (b && !mon_clk_i) begin
            if (armed && (cyc - last_rise) <= TIMEOUT && sb_en) sbq.push_back(cyc - last_rise);
            armed     = 1'b1;
            last_rise = cyc;
        end
        mon_clk_i = b;
        step();
    endtask

    task automatic run_mon(input int p, input int n);
        for (int i = 0; i < n; i++) begin
            set_mon(1'b1);
            repeat (p/2 - 1) step();
            set_mon(1'b0);
            repeat (p - p/2 - 1) step();
        end
    endtask

    initial begin
        reset_i = 1'b0; mon_clk_i = 1'b0; clear_i = 1'b0; ready_i = 1'b1;
        #2 reset_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_v", 32'(v_o), 0);
        chk("rst_period", 32'(period_o), 0);
        chk("rst_err", 32'(err_o), 0);
        chk("rst_overrun", 32'(overrun_o), 0);
        chk("rst_stall", 32'(stall_o), 0);
`ifdef BSG_CLOCK_MON_MINMAX_EN
        chk("rst_min", 32'(min_o), 32'hFFFF);
        chk("rst_max", 32'(max_o), 0);
`endif
        reset_i = 1'b0;
        repeat (3) step();

        // nominal period
        run_mon(10, 4);
        chk("t1_err", 32'(err_o), 0);

        // long period sets sticky err; clear then nominal keeps it low
        run_mon(12, 3);
        run_mon(10, 1);
        chk("t2_err_set", 32'(err_o), 1);
        clr_pend = 1'b1;
        run_mon(10, 3);
        chk("t2_err_clr", 32'(err_o), 0);

        // consumer stalls across three edges
        ready_i = 1'b0; sb_en = 1'b0;
        run_mon(10, 3);
        chk("t3_v", 32'(v_o), 1);
        chk("t3_period", 32'(period_o), 10);
        chk("t3_overrun", 32'(overrun_o), 1);
        sbq.push_back(10);
        ready_i = 1'b1;
        step();
        ready_i = 1'b0;
        chk("t3_v_drop", 32'(v_o), 0);
        chk("t3_period_hold", 32'(period_o), 10);
        ready_i = 1'b1; sb_en = 1'b1;
        clr_pend = 1'b1;
        step();
        chk("t3_overrun_clr", 32'(overrun_o), 0);
        chk("t3_err", 32'(err_o), 0);

        // stall: monitored clock held low
        repeat (1100) step();
        chk("t4_stall", 32'(stall_o), 1);
        chk("t4_err", 32'(err_o), 1);
        clr_pend = 1'b1;
        step();
        chk("t4_err_clr", 32'(err_o), 0);
        chk("t4_stall_kept", 32'(stall_o), 1);
        run_mon(10, 1);
        chk("t4_resume", 32'(stall_o), 0);
        run_mon(10, 2);
        chk("t4_err_after", 32'(err_o), 0);

        // tolerance boundaries 9/11 pass, 8 fails
        clr_pend = 1'b1;
        run_mon(9, 1);
        run_mon(11, 1);
        run_mon(10, 2);
        chk("t6_tol_edge", 32'(err_o), 0);
`ifdef BSG_CLOCK_MON_MINMAX_EN
        chk("t6_min", 32'(min_o), 9);
        chk("t6_max", 32'(max_o), 11);
`endif
        clr_pend = 1'b1;
        step();
`ifdef BSG_CLOCK_MON_MINMAX_EN
        chk("t6_min_clr", 32'(min_o), 32'hFFFF);
        chk("t6_max_clr", 32'(max_o), 0);
`endif
        run_mon(8, 2);
        run_mon(10, 1);
        chk("t6_err_low", 32'(err_o), 1);
`ifdef BSG_CLOCK_MON_MINMAX_EN
        chk("t6_min8", 32'(min_o), 8);
        chk("t6_max11", 32'(max_o), 11);
`endif
        clr_pend = 1'b1;
        step();
        chk("t6_err_clr", 32'(err_o), 0);

        // async reset with a pending report
        ready_i = 1'b0; sb_en = 1'b0;
        run_mon(10, 2);
        repeat (2) step();
        chk("t5_pre_v", 32'(v_o), 1);
        chk("t5_pre_overrun", 32'(overrun_o), 1);
        reset_i = 1'b1;
        #1;
        chk("t5_v", 32'(v_o), 0);
        chk("t5_period", 32'(period_o), 0);
        chk("t5_overrun", 32'(overrun_o), 0);
        chk("t5_err", 32'(err_o), 0);
        chk("t5_stall", 32'(stall_o), 0);
        repeat (2) step();
        reset_i = 1'b0;
        armed = 1'b0;
        sbq.delete();
        ready_i = 1'b1; sb_en = 1'b1;
        run_mon(10, 3);
        repeat (6) step();
        chk("sb_drain", 32'(sbq.size()), 0);
        chk("final_err", 32'(err_o), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
